reg_wr_ctrl: RTL and testbench

Write-side controller for the register file's single write port (addr_3/we_3/wd_3). It accepts writeback requests from two producers, ALU and load unit, over valid/ready handshakes. Requests are buffered in an in-order queue and drained at one write per cycle. Read-after-write bypass data is supplied for both read addresses, so the read side never sees stale values while writes are still pending.

---
 rtl/reg_wr_ctrl.sv | 129 ++++++++++++
 tb/tb_reg_wr_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_ctrl.sv
// reg_wr_ctrl: write-side controller for the register file write port.
// Merges ALU and load writeback requests into an in-order queue. The queue
// drains one write per cycle into addr_3/we_3/wd_3. Read-after-write bypass
// data is produced for byp_addr_1/byp_addr_2.
// Ports: clk, rst (async, active high); alu_* and ld_* valid/ready request
// channels; addr_3/we_3/wd_3 write port; byp_addr_n in, byp_hit_n/byp_data_n
// out; pending/full/empty report the queue occupancy.
// Optional macro REG_WR_STALL_EN adds input wr_stall, which blocks draining.
module reg_wr_ctrl #(
    parameter int ADW   = 5,
    parameter int DPW   = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef REG_WR_STALL_EN
    input  logic                       wr_stall,
`endif
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADW-1:0]             alu_addr,
    input  logic [DPW-1:0]             alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADW-1:0]             ld_addr,
    input  logic [DPW-1:0]             ld_data,
    output logic [ADW-1:0]             addr_3,
    output logic                       we_3,
    output logic [DPW-1:0]             wd_3,
    input  logic [ADW-1:0]             byp_addr_1,
    input  logic [ADW-1:0]             byp_addr_2,
    output logic                       byp_hit_1,
    output logic                       byp_hit_2,
    output logic [DPW-1:0]             byp_data_1,
    output logic [DPW-1:0]             byp_data_2,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADW-1:0] q_addr [DEPTH];
    logic [DPW-1:0] q_data [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic           ld_push, alu_push, pop;

    // Load owns the last free slot, so the ALU needs two when a load is offered.
    assign ld_ready  = count <= CW'(DEPTH-1);
    assign alu_ready = count <= CW'(ld_valid ? DEPTH-2 : DEPTH-1);
    assign ld_push   = ld_valid && ld_ready && ld_addr != '0;
    assign alu_push  = alu_valid && alu_ready && alu_addr != '0;
`ifdef REG_WR_STALL_EN
    assign pop       = count != '0 && !wr_stall;
`else
    assign pop       = count != '0;
`endif
    assign pending   = count;
    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            we_3   <= 1'b0;
            addr_3 <= '0;
            wd_3   <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(ld_push) + PW'(alu_push);
            count  <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
            we_3   <= pop;
            if (pop) begin
                addr_3 <= q_addr[rd_ptr];
                wd_3   <= q_data[rd_ptr];
            end
        end
    end

    // Load is the older entry when both producers push together.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            q_addr[wr_ptr] <= ld_addr;
            q_data[wr_ptr] <= ld_data;
        end
        if (alu_push) begin
            q_addr[wr_ptr + PW'(ld_push)] <= alu_addr;
            q_data[wr_ptr + PW'(ld_push)] <= alu_data;
        end
    end

    // Scan oldest to youngest (output register, then head to tail) so the
    // last match wins.
    always_comb begin
        byp_hit_1  = 1'b0;
        byp_data_1 = '0;
        byp_hit_2  = 1'b0;
        byp_data_2 = '0;
        if (we_3 && addr_3 == byp_addr_1) begin
            byp_hit_1  = 1'b1;
            byp_data_1 = wd_3;
        end
        if (we_3 && addr_3 == byp_addr_2) begin
            byp_hit_2  = 1'b1;
            byp_data_2 = wd_3;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && q_addr[rd_ptr + PW'(i)] == byp_addr_1) begin
                byp_hit_1  = 1'b1;
                byp_data_1 = q_data[rd_ptr + PW'(i)];
            end
            if (CW'(i) < count && q_addr[rd_ptr + PW'(i)] == byp_addr_2) begin
                byp_hit_2  = 1'b1;
                byp_data_2 = q_data[rd_ptr + PW'(i)];
            end
        end
        if (byp_addr_1 == '0) begin
            byp_hit_1  = 1'b0;
            byp_data_1 = '0;
        end
        if (byp_addr_2 == '0) begin
            byp_hit_2  = 1'b0;
            byp_data_2 = '0;
        end
    end
endmodule

// File: tb/tb_reg_wr_ctrl.sv
// tb_reg_wr_ctrl: directed vector bench for reg_wr_ctrl.
module tb_reg_wr_ctrl;
    logic        clk, rst;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [4:0]  alu_addr, ld_addr, addr_3, byp_addr_1, byp_addr_2;
    logic [31:0] alu_data, ld_data, wd_3, byp_data_1, byp_data_2;
    logic        we_3, byp_hit_1, byp_hit_2, full, empty;
    logic [2:0]  pending;
`ifdef REG_WR_STALL_EN
    logic        wr_stall;
`endif
    int n_chk, n_fail;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ldd;
        logic [4:0]  b1, b2;
        logic        ar, lr;
        logic [2:0]  pend;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    vec_t tv [24];

    reg_wr_ctrl dut (
        .clk(clk), .rst(rst),
`ifdef REG_WR_STALL_EN
        .wr_stall(wr_stall),
`endif
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .addr_3(addr_3), .we_3(we_3), .wd_3(wd_3),
        .byp_addr_1(byp_addr_1), .byp_addr_2(byp_addr_2),
        .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
        .byp_data_1(byp_data_1), .byp_data_2(byp_data_2),
        .pending(pending), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ldd,
        input logic [4:0] b1, input logic [4:0] b2,
        input logic ar, input logic lr, input logic [2:0] pend,
        input logic we, input logic [4:0] a3, input logic [31:0] wd,
        input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ldd = ldd;
        v.b1 = b1; v.b2 = b2; v.ar = ar; v.lr = lr; v.pend = pend;
        v.we = we; v.a3 = a3; v.wd = wd; v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        byp_addr_1 = '0; byp_addr_2 = '0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        idle_inputs();
`ifdef REG_WR_STALL_EN
        wr_stall = 1'b0;
`endif
        tv[0]  = mk(0,0,0,            0,0,0,      0,0,   1,1,0, 0,0,0,            0,0,0,0);
        tv[1]  = mk(1,7,32'hDEADBEEF, 0,0,0,      7,0,   1,1,0, 0,0,0,            0,0,0,0);
        tv[2]  = mk(0,0,0,            0,0,0,      7,7,   1,1,1, 0,0,0,            1,32'hDEADBEEF,1,32'hDEADBEEF);
        tv[3]  = mk(0,0,0,            0,0,0,      7,3,   1,1,0, 1,7,32'hDEADBEEF, 1,32'hDEADBEEF,0,0);
        tv[4]  = mk(1,4,32'hB,        1,3,32'hA,  3,4,   1,1,0, 0,7,32'hDEADBEEF, 0,0,0,0);
        tv[5]  = mk(0,0,0,            0,0,0,      3,4,   1,1,2, 0,7,32'hDEADBEEF, 1,32'hA,1,32'hB);
        tv[6]  = mk(0,0,0,            0,0,0,      3,4,   1,1,1, 1,3,32'hA,        1,32'hA,1,32'hB);
        tv[7]  = mk(0,0,0,            0,0,0,      3,4,   1,1,0, 1,4,32'hB,        0,0,1,32'hB);
        tv[8]  = mk(1,9,32'h1,        0,0,0,      9,0,   1,1,0, 0,4,32'hB,        0,0,0,0);
        tv[9]  = mk(1,9,32'h2,        0,0,0,      9,0,   1,1,1, 0,4,32'hB,        1,32'h1,0,0);
        tv[10] = mk(0,0,0,            0,0,0,      9,0,   1,1,1, 1,9,32'h1,        1,32'h2,0,0);
        tv[11] = mk(0,0,0,            0,0,0,      9,0,   1,1,0, 1,9,32'h2,        1,32'h2,0,0);
        tv[12] = mk(0,0,0,            0,0,0,      9,0,   1,1,0, 0,9,32'h2,        0,0,0,0);
        tv[13] = mk(1,0,32'hFFFF,     0,0,0,      0,0,   1,1,0, 0,9,32'h2,        0,0,0,0);
        tv[14] = mk(0,0,0,            0,0,0,      0,0,   1,1,0, 0,9,32'h2,        0,0,0,0);
        tv[15] = mk(1,2,32'h20,       1,1,32'h10, 0,0,   1,1,0, 0,9,32'h2,        0,0,0,0);
        tv[16] = mk(1,6,32'h60,       1,5,32'h50, 1,2,   1,1,2, 0,9,32'h2,        1,32'h10,1,32'h20);
        tv[17] = mk(1,10,32'hA0,      1,8,32'h80, 1,6,   0,1,3, 1,1,32'h10,       1,32'h10,1,32'h60);
        tv[18] = mk(1,10,32'hA0,      0,0,0,      8,10,  1,1,3, 1,2,32'h20,       1,32'h80,0,0);
        tv[19] = mk(0,0,0,            0,0,0,      5,10,  1,1,3, 1,5,32'h50,       1,32'h50,1,32'hA0);
        tv[20] = mk(0,0,0,            0,0,0,      6,8,   1,1,2, 1,6,32'h60,       1,32'h60,1,32'h80);
        tv[21] = mk(0,0,0,            0,0,0,      8,10,  1,1,1, 1,8,32'h80,       1,32'h80,1,32'hA0);
        tv[22] = mk(0,0,0,            0,0,0,      10,8,  1,1,0, 1,10,32'hA0,      1,32'hA0,0,0);
        tv[23] = mk(0,0,0,            0,0,0,      0,0,   1,1,0, 0,10,32'hA0,      0,0,0,0);

        repeat (2) @(negedge clk);
        chk("rst.we_3", we_3, 0);
        chk("rst.addr_3", addr_3, 0);
        chk("rst.wd_3", wd_3, 0);
        chk("rst.pending", pending, 0);
        chk("rst.empty", empty, 1);
        chk("rst.full", full, 0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            alu_valid = tv[i].av; alu_addr = tv[i].aa; alu_data = tv[i].ad;
            ld_valid = tv[i].lv; ld_addr = tv[i].la; ld_data = tv[i].ldd;
            byp_addr_1 = tv[i].b1; byp_addr_2 = tv[i].b2;
            #1;
            chk($sformatf("v%0d.alu_ready", i), alu_ready, tv[i].ar);
            chk($sformatf("v%0d.ld_ready", i), ld_ready, tv[i].lr);
            chk($sformatf("v%0d.pending", i), pending, tv[i].pend);
            chk($sformatf("v%0d.full", i), full, tv[i].pend == 3'd4);
            chk($sformatf("v%0d.empty", i), empty, tv[i].pend == 3'd0);
            chk($sformatf("v%0d.we_3", i), we_3, tv[i].we);
            chk($sformatf("v%0d.addr_3", i), addr_3, tv[i].a3);
            chk($sformatf("v%0d.wd_3", i), wd_3, tv[i].wd);
            chk($sformatf("v%0d.byp_hit_1", i), byp_hit_1, tv[i].h1);
            chk($sformatf("v%0d.byp_data_1", i), byp_data_1, tv[i].d1);
            chk($sformatf("v%0d.byp_hit_2", i), byp_hit_2, tv[i].h2);
            chk($sformatf("v%0d.byp_data_2", i), byp_data_2, tv[i].d2);
        end

        // Reset while draining with three entries queued.
        @(negedge clk);
        idle_inputs();
        ld_valid = 1; ld_addr = 1; ld_data = 1; alu_valid = 1; alu_addr = 2; alu_data = 2;
        @(negedge clk);
        ld_addr = 3; ld_data = 3; alu_addr = 4; alu_data = 4;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mid.pending", pending, 3);
        chk("mid.we_3", we_3, 1);
        chk("mid.addr_3", addr_3, 1);
        rst = 1'b1;
        #1;
        chk("arst.pending", pending, 0);
        chk("arst.we_3", we_3, 0);
        chk("arst.addr_3", addr_3, 0);
        chk("arst.wd_3", wd_3, 0);
        chk("arst.empty", empty, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        alu_valid = 1; alu_addr = 5; alu_data = 32'h11;
        #1;
        chk("post.alu_ready", alu_ready, 1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("post.n0.we_3", we_3, 0);
        chk("post.n0.pending", pending, 1);
        @(negedge clk);
        #1;
        chk("post.n1.we_3", we_3, 1);
        chk("post.n1.addr_3", addr_3, 5);
        chk("post.n1.wd_3", wd_3, 32'h11);
        @(negedge clk);
        #1;
        chk("post.n2.we_3", we_3, 0);
        chk("post.n2.pending", pending, 0);

`ifdef REG_WR_STALL_EN
        // Fill under stall, hold a fifth load, then release and drain in order.
        repeat (2) @(negedge clk);
        wr_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ld_valid = 1; ld_addr = 5'(i); ld_data = 32'h100 + i;
            @(negedge clk);
        end
        ld_addr = 5; ld_data = 32'h105;
        #1;
        chk("stall.full", full, 1);
        chk("stall.ld_ready", ld_ready, 0);
        chk("stall.pending", pending, 4);
        chk("stall.we_3", we_3, 0);
        @(negedge clk);
        #1;
        chk("stall.hold.pending", pending, 4);
        chk("stall.hold.we_3", we_3, 0);
        wr_stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) ld_valid = 1'b0;
            #1;
            chk($sformatf("drain%0d.we_3", k), we_3, 1);
            chk($sformatf("drain%0d.addr_3", k), addr_3, k);
            chk($sformatf("drain%0d.wd_3", k), wd_3, 32'h100 + k);
        end
        @(negedge clk);
        #1;
        chk("drain.end.we_3", we_3, 0);
        chk("drain.end.empty", empty, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
